load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage that sits directly upstream of the data memory and serves the execute stage over a valid/ready request and response interface.
- Checks address alignment and funct3 legality.
- Issues word-aligned reads and writes to the data memory port.
- Sign- or zero-extends load results.
- Performs sub-word stores (SB/SH) as a read-modify-write, because the memory port writes whole words only.

Parameters:
DM_ADDRESS, 9, byte-address width seen by data memory
DATA_W, 32, data word width (only 32 supported)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  instruction bits 14:12
req_addr  in  DM_ADDRESS  byte address (ALU result LSBs)
req_wdata  in  DATA_W  store data (rs2)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or illegal funct3; qualified by rsp_valid
mem_addr  out  DM_ADDRESS  word-aligned address, low 2 bits always 0
mem_re  out  1  read strobe
mem_we  out  1  full-word write strobe
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  valid the cycle after mem_re; held until the next mem_re

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n).
- Reset values: state=IDLE; req_ready=1 after reset release; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request capture: on req_valid&req_ready, latch we, funct3, addr, wdata.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Error path: illegal funct3 or misaligned address -> no memory strobe; rsp_valid=1 with rsp_err=1 in the cycle after acceptance; stay in IDLE.
- FSM states: IDLE, LD_RD, LD_CAP, ST_RD, ST_WR.
  - IDLE -> LD_RD on a legal load.
  - IDLE -> ST_WR on SW.
  - IDLE -> ST_RD on SB/SH.
  - LD_RD: mem_re=1. Next state LD_CAP.
  - LD_CAP: select lane addr[1:0] (byte) or addr[1] (half) from mem_rdata; sign-extend for LB/LH, zero-extend for LBU/LHU. Register the result into rsp_rdata. Next state IDLE with rsp_valid=1.
  - ST_RD: mem_re=1. Next state ST_WR.
  - ST_WR: mem_we=1.
    - SW: mem_wdata=wdata.
    - SB/SH: mem_wdata = mem_rdata with the addressed byte/half replaced by wdata[7:0] / wdata[15:0].
    - Next state IDLE with rsp_valid=1, rsp_rdata=0.
- mem_re, mem_we and mem_addr are decoded from state. They are never both high.
- Latency (acceptance edge = cycle 0):
  - Load: rsp_valid in cycle 3.
  - SW: rsp_valid in cycle 2.
  - SB/SH: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
- rsp_valid is a single-cycle pulse; there is no response backpressure.
- A new request may be accepted in the same cycle rsp_valid is high.
- Requests arriving while req_ready=0 are ignored; the requester must hold them.
- Reset mid-operation:
  - Return to IDLE immediately; drop the pending response.
  - An RMW reset in ST_RD never issues its write, so memory is unchanged.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_t (IDLE, LD_RD, LD_CAP, ST_RD, ST_WR);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, lsu_lane_align:
  - load extract/extend: word, funct3, offset -> result;
  - store merge: old word, wdata, funct3, offset -> new word.

Test Plan:
- Preload word@0x10=0x8899AABB; LB addr 0x11 -> mem_re cycle 1, mem_addr=0x10, rsp_valid cycle 3, rsp_rdata=0xFFFFFFAA, rsp_err=0.
- Same word; LHU addr 0x12 -> rsp_rdata=0x00008899. LH addr 0x12 -> 0xFFFF8899. LW addr 0x10 -> 0x8899AABB.
- SB addr 0x13, wdata=0x12345655 -> mem_re cycle 1, mem_we cycle 2 with mem_wdata=0x5599AABB; a subsequent LW 0x10 returns 0x5599AABB.
- LW addr 0x12, then SH addr 0x11, then funct3=011 load -> each gives rsp_valid cycle 1 with rsp_err=1, rsp_rdata=0; mem_re and mem_we never asserted.
- Back-to-back: SW 0x20 data 0xDEADBEEF accepted while the previous response pulses; then LW 0x20 -> 0xDEADBEEF; req_ready low exactly during busy states.
- SH addr 0x10 data 0xCAFE; drive rst_n=0 during ST_RD -> no mem_we; state IDLE, req_ready=1 after release; memory word unchanged; no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// State encoding, funct3 codes and access checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    ST_RD,
    ST_WR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] lsb
  );
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = lsb[0];
      F3_W:        bad = |lsb;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic is_legal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte/half lane extraction for loads and lane merge for stores.
// Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    ld_data = '0;
    unique case (funct3)
      F3_B:    ld_data = {{24{b[7]}}, b};
      F3_H:    ld_data = {{16{h[15]}}, h};
      F3_W:    ld_data = word;
      F3_BU:   ld_data = {24'd0, b};
      F3_HU:   ld_data = {16'd0, h};
      default: ld_data = '0;
    endcase
  end

  // Unaddressed lanes keep the word just read back.
  always_comb begin
    st_data = word;
    unique case (funct3)
      F3_B: st_data[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) st_data[31:16] = wdata[15:0];
        else           st_data[15:0]  = wdata[15:0];
      end
      F3_W:    st_data = wdata;
      default: st_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: alignment checks, word-wide memory port,
// load extension and read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t state, state_nxt;

  logic                  r_we;
  logic [2:0]            r_f3;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic        accept;
  logic        req_bad;
  logic [31:0] ld_data;
  logic [31:0] st_data;

  assign accept  = req_valid & req_ready;
  assign req_bad = !is_legal(req_we, req_funct3)
                 || is_misaligned(req_funct3, req_addr[1:0]);

  lsu_lane_align u_align (
    .word    (mem_rdata),
    .wdata   (r_wdata),
    .funct3  (r_f3),
    .offset  (r_addr[1:0]),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && !req_bad) begin
          unique case (1'b1)
            !req_we:                      state_nxt = LD_RD;
            req_we && req_funct3 == F3_W: state_nxt = ST_WR;
            default:                      state_nxt = ST_RD;
          endcase
        end
      end
      LD_RD:   state_nxt = LD_CAP;
      LD_CAP:  state_nxt = IDLE;
      ST_RD:   state_nxt = ST_WR;
      ST_WR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_re    = (state == LD_RD) || (state == ST_RD);
    mem_we    = (state == ST_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_re || mem_we)
      mem_addr = {r_addr[DM_ADDRESS-1:2], 2'b00};
    if (mem_we)
      mem_wdata = st_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (accept) begin
      r_we    <= req_we;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response is a one-cycle pulse; data is zero unless a load completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (accept && req_bad) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end else if (state == LD_CAP && !r_we) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= ld_data;
      end else if (state == ST_WR) begin
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-array memory
// and a reference model working on plain byte arithmetic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] tbmem [128];
  logic [31:0] refmem [128];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= tbmem[mem_addr[8:2]];
    if (mem_we) tbmem[mem_addr[8:2]] <= mem_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;
  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int errors = 0;
  int checks = 0;
  int busy_lo = -1;
  int busy_hi = -2;
  int re_cyc = -1;
  logic [8:0] re_addr = '0;
  bit mon_en = 1'b0;

  function automatic bit model_bad(input logic we, input logic [2:0] f3,
                                   input logic [8:0] a);
    int o;
    bit legal;
    o = int'(a) % 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (o % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && o != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ld_ref(input logic [31:0] w,
                                         input logic [2:0] f3,
                                         input logic [8:0] a);
    int o, bv, hv;
    o  = int'(a) % 4;
    bv = int'((w >> (8 * o)) & 32'hFF);
    hv = int'((w >> (16 * (o / 2))) & 32'hFFFF);
    case (f3)
      3'd0: begin if (bv > 127) bv = bv - 256; return 32'(bv); end
      3'd1: begin if (hv > 32767) hv = hv - 65536; return 32'(hv); end
      3'd2: return w;
      3'd4: return 32'(bv);
      default: return 32'(hv);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      rsp_t r;
      wr_t  w;
      checks++;
      if (req_ready !== !(edges >= busy_lo && edges <= busy_hi)) begin
        errors++;
        $display("FAIL ready edge=%0d got=%b", edges, req_ready);
      end
      checks++;
      if (mem_re !== (edges == re_cyc)) begin
        errors++;
        $display("FAIL mem_re edge=%0d got=%b want=%b",
                 edges, mem_re, edges == re_cyc);
      end
      if (mem_re) begin
        checks++;
        if (mem_addr !== re_addr) begin
          errors++;
          $display("FAIL rd_addr got=%h want=%h", mem_addr, re_addr);
        end
      end
      if (mem_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h",
                   mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          if (mem_addr !== w.addr || mem_wdata !== w.data || mem_re) begin
            errors++;
            $display("FAIL write got=%h:%h want=%h:%h re=%b",
                     mem_addr, mem_wdata, w.addr, w.data, mem_re);
          end
        end
      end
      if (rsp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp data=%h err=%b", rsp_rdata, rsp_err);
        end else begin
          r = rq.pop_front();
          if (rsp_rdata !== r.rdata || rsp_err !== r.err || edges != r.due) begin
            errors++;
            $display("FAIL rsp got=%h/%b@%0d want=%h/%b@%0d",
                     rsp_rdata, rsp_err, edges, r.rdata, r.err, r.due);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] wd,
                       input bit abort);
    int n, acc, lat, wi, sh;
    bit bad;
    logic [31:0] exp, w, m;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h", a);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = edges;
    if (abort) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      busy_lo = -1;
      busy_hi = -2;
      re_cyc = -1;
      return;
    end
    bad = model_bad(we, f3, a);
    wi = int'(a) / 4;
    sh = 8 * (int'(a) % 4);
    re_cyc = -1;
    exp = '0;
    if (bad) begin
      lat = 1;
    end else if (!we) begin
      exp = ld_ref(refmem[wi], f3, a);
      lat = 3;
      re_cyc = acc;
      re_addr = 9'(wi * 4);
    end else begin
      w = refmem[wi];
      if (f3 == 3'd2) begin
        w = wd;
        lat = 2;
      end else begin
        m = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        w = (w & ~(m << sh)) | ((wd & m) << sh);
        lat = 3;
        re_cyc = acc;
        re_addr = 9'(wi * 4);
      end
      refmem[wi] = w;
      wq.push_back('{9'(wi * 4), w});
    end
    busy_lo = acc;
    busy_hi = acc + lat - 2;
    rq.push_back('{exp, bad, acc + lat - 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout rsp=%0d wr=%0d", rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tbmem[i] = $urandom;
      refmem[i] = tbmem[i];
    end
    tbmem[4] = 32'h8899AABB;
    refmem[4] = 32'h8899AABB;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    mon_en = 1'b1;

    issue(1'b0, 3'b000, 9'h11, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 9'h12, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 9'h12, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 9'h10, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 9'h13, 32'h12345655, 1'b0);
    issue(1'b0, 3'b010, 9'h10, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 9'h12, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 9'h11, 32'h0, 1'b0);
    issue(1'b0, 3'b011, 9'h10, 32'h0, 1'b0);
    issue(1'b1, 3'b010, 9'h20, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'b010, 9'h20, 32'h0, 1'b0);
    drain();
    chk("sb_merge_word", tbmem[4], 32'h5599AABB);

    issue(1'b1, 3'b001, 9'h10, 32'h0000CAFE, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_mid_mem", tbmem[4], refmem[4]);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 250; i++) begin
      issue(1'($urandom % 2), 3'($urandom % 8), 9'($urandom % 64),
            $urandom, 1'b0);
    end
    drain();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) chk("mem_final", tbmem[i], refmem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
